// File: rtl/mio_pkg.sv
// mio_pkg: address map, FSM state type and default RAM latency shared by the
// memory/IO responder and its address decoder.
// Ports: none (package only).
package mio_pkg;

  // Memory map (byte addresses; the two LSBs are always ignored).
  localparam logic [31:0] RAM_BASE  = 32'h0000_0000;
  localparam logic [31:0] GPIO_ADDR = 32'hF000_0000;
  localparam logic [31:0] SW_ADDR   = 32'hF000_0004;
  localparam logic [31:0] CNT_ADDR  = 32'hF000_0008;

  // Default RAM read latency in cycles (ram_addr valid -> ram_rdata valid).
  localparam int RAM_LATENCY_DEFAULT = 2;

  // Transaction FSM: WAIT is only entered for RAM reads.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mio_addr_decode.sv
// mio_addr_decode: combinational one-hot region decode of a CPU byte address.
// Latency: 0 cycles (pure combinational). Backpressure: none.
// Ports: i_cpu_addr -> o_sel_ram / o_sel_gpio / o_sel_sw / o_sel_cnt / o_sel_none.
module mio_addr_decode
  import mio_pkg::*;
#(
  parameter int RAM_AW = 10
) (
  input  logic [31:0] i_cpu_addr,
  output logic        o_sel_ram,
  output logic        o_sel_gpio,
  output logic        o_sel_sw,
  output logic        o_sel_cnt,
  output logic        o_sel_none
);

  // Byte lanes are not decoded; word-aligned behaviour for any offset.
  logic w_unused_addr_lsbs;
  assign w_unused_addr_lsbs = ^i_cpu_addr[1:0];

  // RAM occupies the bottom 4*2^RAM_AW bytes: everything above the word
  // index must match the base.
  assign o_sel_ram  = (i_cpu_addr[31:RAM_AW+2] == RAM_BASE[31:RAM_AW+2]);
  assign o_sel_gpio = (i_cpu_addr[31:2] == GPIO_ADDR[31:2]);
  assign o_sel_sw   = (i_cpu_addr[31:2] == SW_ADDR[31:2]);
  assign o_sel_cnt  = (i_cpu_addr[31:2] == CNT_ADDR[31:2]);
  assign o_sel_none = ~(o_sel_ram | o_sel_gpio | o_sel_sw | o_sel_cnt);

endmodule

// File: rtl/mio_responder.sv
// mio_responder: CPU-side responder for a RAM window, GPIO, switch input and a free-running counter.
// Latency: peripheral/unmapped/RAM-write 1 cycle to mio_ready; RAM read RAM_LATENCY+1 cycles.
// Backpressure: CPU holds cpu_req until the single-cycle mio_ready strobe; no new request taken until IDLE.
// Ports: clk/rst (async, active-high); cpu_req/we/addr/wdata in, cpu_rdata/mio_ready out;
//        ram_addr/ram_we/ram_wdata out, ram_rdata in; sw_in in; led_out = gpio_reg[7:0].
module mio_responder
  import mio_pkg::*;
#(
  parameter int RAM_LATENCY = RAM_LATENCY_DEFAULT,
  parameter int RAM_AW      = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              mio_ready,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  input  logic [15:0]       sw_in,
  output logic [7:0]        led_out
);

  // WAIT lasts RAM_LATENCY cycles; the counter runs down to zero and the
  // WAIT->RESP edge is the one that captures ram_rdata.
  localparam logic [3:0] LAT_LOAD = 4'(RAM_LATENCY - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_lat_cnt;
  logic [31:0]       r_gpio;
  logic [31:0]       r_cnt;
  logic [31:0]       r_cpu_rdata;
  logic [31:0]       r_ram_wdata;
  logic [RAM_AW-1:0] r_ram_addr;
  logic              r_ram_we;

  logic              w_sel_ram;
  logic              w_sel_gpio;
  logic              w_sel_sw;
  logic              w_sel_cnt;
  logic              w_sel_none;
  logic              w_accept;
  logic              w_lat_done;
  logic [31:0]       w_periph_rdata;

  mio_addr_decode #(
    .RAM_AW (RAM_AW)
  ) u_decode (
    .i_cpu_addr (cpu_addr),
    .o_sel_ram  (w_sel_ram),
    .o_sel_gpio (w_sel_gpio),
    .o_sel_sw   (w_sel_sw),
    .o_sel_cnt  (w_sel_cnt),
    .o_sel_none (w_sel_none)
  );

  assign w_accept   = (r_state == IDLE) && cpu_req;
  assign w_lat_done = (r_lat_cnt == 4'd0);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and completion strobe
  always_comb begin
    w_state_nxt = r_state;
    mio_ready   = 1'b0;
    case (r_state)
      IDLE: begin
        if (cpu_req) begin
          w_state_nxt = (w_sel_ram && !cpu_we) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (w_lat_done) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        mio_ready   = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Peripheral read mux; unmapped reads fall through to zero.
  always_comb begin
    w_periph_rdata = 32'h0;
    if (w_sel_gpio) begin
      w_periph_rdata = r_gpio;
    end else if (w_sel_sw) begin
      w_periph_rdata = {16'h0, sw_in};
    end else if (w_sel_cnt) begin
      w_periph_rdata = r_cnt;
    end else if (w_sel_none) begin
      w_periph_rdata = 32'h0;
    end
  end

  // Datapath: counter, GPIO, RAM port registers and read-data capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= 32'h0;
      r_gpio      <= 32'h0;
      r_cpu_rdata <= 32'h0;
      r_ram_addr  <= '0;
      r_ram_wdata <= 32'h0;
      r_ram_we    <= 1'b0;
      r_lat_cnt   <= 4'd0;
    end else begin
      // Free-running increment; a CNT write below overrides it on this edge.
      r_cnt    <= r_cnt + 32'd1;
      r_ram_we <= 1'b0;

      if (w_accept) begin
        if (w_sel_ram) begin
          r_ram_addr <= cpu_addr[RAM_AW+1:2];
          if (cpu_we) begin
            r_ram_we    <= 1'b1;
            r_ram_wdata <= cpu_wdata;
          end else begin
            r_lat_cnt <= LAT_LOAD;
          end
        end
        if (w_sel_gpio && cpu_we) begin
          r_gpio <= cpu_wdata;
        end
        if (w_sel_cnt && cpu_we) begin
          r_cnt <= cpu_wdata;
        end
        // Peripheral reads complete next cycle, so capture now; cpu_rdata
        // is otherwise left alone and holds the last read result.
        if (!cpu_we && !w_sel_ram) begin
          r_cpu_rdata <= w_periph_rdata;
        end
      end else if (r_state == WAIT) begin
        if (w_lat_done) begin
          r_cpu_rdata <= ram_rdata;
        end else begin
          r_lat_cnt <= r_lat_cnt - 4'd1;
        end
      end
    end
  end

  assign cpu_rdata = r_cpu_rdata;
  assign ram_addr  = r_ram_addr;
  assign ram_we    = r_ram_we;
  assign ram_wdata = r_ram_wdata;
  assign led_out   = r_gpio[7:0];

endmodule

// File: tb/tb_mio_responder.sv
// tb_mio_responder: self-checking bench for mio_responder (RAM_LATENCY=2, RAM_AW=10).
// A registered-output RAM model sits on the RAM port; expectations come from a
// transaction-level model of the address map kept in plain arrays and counters.
module tb_mio_responder;
  import mio_pkg::*;

  localparam int LAT       = 2;
  localparam int AW        = 10;
  localparam int RAM_BYTES = 4 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req;
  logic          cpu_we;
  logic [31:0]   cpu_addr;
  logic [31:0]   cpu_wdata;
  logic [31:0]   cpu_rdata;
  logic          mio_ready;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;
  logic [15:0]   sw_in;
  logic [7:0]    led_out;

  mio_responder #(
    .RAM_LATENCY (LAT),
    .RAM_AW      (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .mio_ready (mio_ready),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .sw_in     (sw_in),
    .led_out   (led_out)
  );

  always #5 clk = ~clk;

  // RAM device: synchronous write, one output register stage. Together with
  // the address register in the DUT that gives data valid LAT cycles after
  // the request is accepted.
  logic [31:0] dev_mem [1024];
  logic [31:0] rd_q;
  always @(posedge clk) begin
    if (ram_we) dev_mem[ram_addr] <= ram_wdata;
    rd_q <= dev_mem[ram_addr];
  end
  assign ram_rdata = rd_q;

  // Edge index since reset release, and count of ram_we pulses.
  int cyc;
  int ram_we_cnt = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end
  always @(posedge clk) if (ram_we) ram_we_cnt <= ram_we_cnt + 1;

  int n_asserts = 0;
  int n_fail    = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_mem [1024];
  logic [31:0] m_gpio;
  logic [31:0] m_cnt_base;   // counter value right after the last load/reset
  int          m_cnt_cyc;    // edge index of that load/reset
  logic [31:0] m_last_rd;

  task automatic model_reset();
    m_gpio     = 32'h0;
    m_cnt_base = 32'h0;
    m_cnt_cyc  = 0;
    m_last_rd  = 32'h0;
  endtask

  // Applies one accepted transaction (acceptance at edge index acc).
  task automatic model_step(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input int acc, output logic [31:0] exp_rd, output int exp_lat,
                            output int exp_pulses);
    logic [31:0] a;
    a          = addr & 32'hFFFF_FFFC;
    exp_lat    = 1;
    exp_pulses = 0;
    exp_rd     = m_last_rd;
    if (a < RAM_BYTES) begin
      if (we) begin
        m_mem[a[11:2]] = wdata;
        exp_pulses     = 1;
      end else begin
        exp_rd  = m_mem[a[11:2]];
        exp_lat = LAT + 1;
      end
    end else if (a == 32'hF000_0000) begin
      if (we) m_gpio = wdata;
      else    exp_rd = m_gpio;
    end else if (a == 32'hF000_0004) begin
      if (!we) exp_rd = {16'h0, sw_in};
    end else if (a == 32'hF000_0008) begin
      // A read sees the counter as it stands just before the acceptance
      // edge: load value plus the edges that elapsed in between.
      if (we) begin
        m_cnt_base = wdata;
        m_cnt_cyc  = acc;
      end else begin
        exp_rd = m_cnt_base + 32'(acc - m_cnt_cyc - 1);
      end
    end else if (!we) begin
      exp_rd = 32'h0;
    end
    m_last_rd = exp_rd;
  endtask

  // ---------------- CPU transaction driver ----------------
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd, output int lat, output int acc,
                        output int pulses, output logic [31:0] wd_acc);
    int p0;
    bit seen;
    @(negedge clk);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    p0        = ram_we_cnt;
    @(posedge clk); #1;
    acc    = cyc;
    wd_acc = ram_wdata;
    lat    = 0;
    seen   = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (!seen) begin
        if (i > 1) begin
          @(posedge clk); #1;
        end
        if (mio_ready) begin
          lat  = i;
          seen = 1'b1;
        end
      end
    end
    cpu_req = 1'b0;
    rd      = cpu_rdata;
    @(posedge clk); #1;
    chk("ready_single_cycle", 32'(mio_ready), 32'h0);
    pulses = ram_we_cnt - p0;
  endtask

  typedef struct {
    logic          we;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [31:0]   exp_rd;
    int            exp_lat;
    int            exp_pulses;
    logic [AW-1:0] exp_raddr;
    logic [7:0]    exp_led;
  } vec_t;

  vec_t vecs [14];

  initial begin
    logic [31:0] rd, wd, exp_rd, wdv, adr;
    int          lat, acc, pulses, exp_lat, exp_pulses, hits, p0, sel;
    logic        wev;

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'h1234_5678, 32'h0000_1111, 1, 1, 10'h004, 8'h00};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         32'h1234_5678, 3, 0, 10'h004, 8'h00};
    vecs[2]  = '{1'b1, 32'hF000_0000, 32'h0000_00A5, 32'h1234_5678, 1, 0, 10'h004, 8'hA5};
    vecs[3]  = '{1'b0, 32'hF000_0000, 32'h0,         32'h0000_00A5, 1, 0, 10'h004, 8'hA5};
    vecs[4]  = '{1'b0, 32'hF000_0004, 32'h0,         32'h0000_BEEF, 1, 0, 10'h004, 8'hA5};
    vecs[5]  = '{1'b0, 32'h8000_0000, 32'h0,         32'h0000_0000, 1, 0, 10'h004, 8'hA5};
    vecs[6]  = '{1'b1, 32'h8000_0000, 32'hDEAD_BEEF, 32'h0000_0000, 1, 0, 10'h004, 8'hA5};
    vecs[7]  = '{1'b0, 32'hF000_0000, 32'h0,         32'h0000_00A5, 1, 0, 10'h004, 8'hA5};
    vecs[8]  = '{1'b0, 32'h0000_0010, 32'h0,         32'h1234_5678, 3, 0, 10'h004, 8'hA5};
    vecs[9]  = '{1'b0, 32'hF000_0006, 32'h0,         32'h0000_BEEF, 1, 0, 10'h004, 8'hA5};
    vecs[10] = '{1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 32'h0000_BEEF, 1, 1, 10'h3FF, 8'hA5};
    vecs[11] = '{1'b0, 32'h0000_0FFC, 32'h0,         32'hCAFE_F00D, 3, 0, 10'h3FF, 8'hA5};
    vecs[12] = '{1'b0, 32'h0000_1000, 32'h0,         32'h0000_0000, 1, 0, 10'h3FF, 8'hA5};
    vecs[13] = '{1'b0, 32'hF000_000C, 32'h0,         32'h0000_0000, 1, 0, 10'h3FF, 8'hA5};

    for (int i = 0; i < 1024; i++) begin
      dev_mem[i] = 32'h0;
      m_mem[i]   = 32'h0;
    end
    model_reset();

    rst       = 1'b1;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = 32'h0;
    cpu_wdata = 32'h0;
    sw_in     = 16'h1111;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mio_ready", 32'(mio_ready), 32'h0);
    chk("rst_ram_we",    32'(ram_we),    32'h0);
    chk("rst_cpu_rdata", cpu_rdata,      32'h0);
    chk("rst_ram_addr",  32'(ram_addr),  32'h0);
    chk("rst_ram_wdata", ram_wdata,      32'h0);
    chk("rst_led_out",   32'(led_out),   32'h0);

    // Request pending through reset release is taken on the first edge.
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'hF000_0004;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("first_edge_ready", 32'(mio_ready), 32'h1);
    chk("first_edge_rdata", cpu_rdata,      32'h0000_1111);
    model_step(1'b0, 32'hF000_0004, 32'h0, cyc, exp_rd, exp_lat, exp_pulses);
    cpu_req = 1'b0;
    @(posedge clk); #1;
    chk("first_edge_ready_drop", 32'(mio_ready), 32'h0);

    // Directed vector table
    sw_in = 16'hBEEF;
    for (int i = 0; i < 14; i++) begin
      do_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, lat, acc, pulses, wd);
      model_step(vecs[i].we, vecs[i].addr, vecs[i].wdata, acc, exp_rd, exp_lat, exp_pulses);
      chk($sformatf("vec%0d_rdata", i),   rd,            vecs[i].exp_rd);
      chk($sformatf("vec%0d_latency", i), 32'(lat),      32'(vecs[i].exp_lat));
      chk($sformatf("vec%0d_ram_we", i),  32'(pulses),   32'(vecs[i].exp_pulses));
      chk($sformatf("vec%0d_ram_addr", i), 32'(ram_addr), 32'(vecs[i].exp_raddr));
      chk($sformatf("vec%0d_led", i),     32'(led_out),  32'(vecs[i].exp_led));
      if (vecs[i].exp_pulses != 0) chk($sformatf("vec%0d_ram_wdata", i), wd, vecs[i].wdata);
    end

    // CNT load near the top, idle, then read back across the wrap.
    do_txn(1'b1, 32'hF000_0008, 32'hFFFF_FFFE, rd, lat, acc, pulses, wd);
    model_step(1'b1, 32'hF000_0008, 32'hFFFF_FFFE, acc, exp_rd, exp_lat, exp_pulses);
    p0 = acc;
    repeat (3) @(posedge clk);
    do_txn(1'b0, 32'hF000_0008, 32'h0, rd, lat, acc, pulses, wd);
    model_step(1'b0, 32'hF000_0008, 32'h0, acc, exp_rd, exp_lat, exp_pulses);
    chk("cnt_wrap_value", rd, 32'hFFFF_FFFE + 32'(acc - p0 - 1));
    chk("cnt_wrap_small", 32'(rd < 32'h10), 32'h1);

    // Unmapped write leaves the counter and GPIO alone.
    do_txn(1'b1, 32'h8000_0008, 32'h5555_5555, rd, lat, acc, pulses, wd);
    model_step(1'b1, 32'h8000_0008, 32'h5555_5555, acc, exp_rd, exp_lat, exp_pulses);
    chk("unmapped_wr_ram_we", 32'(pulses), 32'h0);
    do_txn(1'b0, 32'hF000_0008, 32'h0, rd, lat, acc, pulses, wd);
    model_step(1'b0, 32'hF000_0008, 32'h0, acc, exp_rd, exp_lat, exp_pulses);
    chk("cnt_after_unmapped_wr", rd, exp_rd);
    chk("led_after_unmapped_wr", 32'(led_out), 32'h0000_00A5);

    // Randomized traffic against the model.
    for (int n = 0; n < 80; n++) begin
      sel   = $urandom_range(0, 4);
      wev   = 1'($urandom_range(0, 1));
      wdv   = $urandom;
      sw_in = 16'($urandom);
      case (sel)
        0:       adr = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
        1:       adr = 32'hF000_0000;
        2:       adr = 32'hF000_0004;
        3:       adr = 32'hF000_0008;
        default: adr = 32'h4000_0000 | ($urandom & 32'h0FFF_FFFC);
      endcase
      repeat ($urandom_range(0, 2)) @(posedge clk);
      do_txn(wev, adr, wdv, rd, lat, acc, pulses, wd);
      model_step(wev, adr, wdv, acc, exp_rd, exp_lat, exp_pulses);
      chk($sformatf("rnd%0d_rdata", n),   rd,          exp_rd);
      chk($sformatf("rnd%0d_latency", n), 32'(lat),    32'(exp_lat));
      chk($sformatf("rnd%0d_ram_we", n),  32'(pulses), 32'(exp_pulses));
      chk($sformatf("rnd%0d_led", n),     32'(led_out), 32'(m_gpio[7:0]));
      if (exp_pulses != 0) chk($sformatf("rnd%0d_ram_wdata", n), wd, wdv);
    end

    // Reset during WAIT of a RAM read aborts it.
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h0000_0010;
    @(posedge clk); #2;
    rst     = 1'b1;
    cpu_req = 1'b0;
    #1;
    chk("abort_rst_ready", 32'(mio_ready), 32'h0);
    chk("abort_rst_rdata", cpu_rdata,      32'h0);
    chk("abort_rst_led",   32'(led_out),   32'h0);
    chk("abort_rst_raddr", 32'(ram_addr),  32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    hits = 0;
    p0   = ram_we_cnt;
    repeat (8) begin
      @(posedge clk); #1;
      if (mio_ready) hits++;
    end
    chk("abort_no_ready", 32'(hits), 32'h0);
    chk("abort_no_ram_we", 32'(ram_we_cnt - p0), 32'h0);
    do_txn(1'b0, 32'h0000_0010, 32'h0, rd, lat, acc, pulses, wd);
    model_step(1'b0, 32'h0000_0010, 32'h0, acc, exp_rd, exp_lat, exp_pulses);
    chk("post_abort_rdata",   rd,       exp_rd);
    chk("post_abort_latency", 32'(lat), 32'(LAT + 1));
    do_txn(1'b0, 32'hF000_0008, 32'h0, rd, lat, acc, pulses, wd);
    model_step(1'b0, 32'hF000_0008, 32'h0, acc, exp_rd, exp_lat, exp_pulses);
    chk("post_abort_cnt", rd, exp_rd);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no end of test, expected completion");
    $fatal(1);
  end

endmodule
